nn_node_mac: RTL and testbench

Parametrised artificial-neural-network node. It accepts one input vector of N_INPUTS signed fixed-point samples, streamed one per beat over a valid/ready handshake. It multiply-accumulates each sample against a locally stored coefficient, adds a bias, rescales and saturates the sum, applies a selectable activation function, and presents one result on a valid/ready output. Nodes are instantiated per neuron inside the layer datapath, and coefficients are loaded by the layer controller while the node is idle.

---
 rtl/nn_pkg.sv | 28 ++
 rtl/nn_activation.sv | 61 ++++++
 rtl/nn_node_mac.sv | 160 ++++++++++++++++
 tb/tb_nn_node_mac.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared types and defaults for neural-network node datapaths.
package nn_pkg;

  // Default sample format, shared with the layer controller.
  localparam int NN_DATA_W    = 16;
  localparam int NN_FRAC_BITS = 8;

  // Activation selector; encoding 3 is reserved and treated as identity.
  typedef enum logic [1:0] {
    ACT_IDENT = 2'd0,
    ACT_RELU  = 2'd1,
    ACT_STEP  = 2'd2
  } act_mode_t;

  // Node sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_ACT   = 2'd2,
    ST_OUT   = 2'd3
  } node_state_t;

  // Index width for n entries, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nn_activation.sv
// Combinational rescale, saturate and activation stage: adds the bias to the
// accumulated dot product, drops the fractional bits (floor), clips to the
// result width and applies the selected activation.
module nn_activation
  import nn_pkg::*;
#(
  parameter int DATA_W    = NN_DATA_W,
  parameter int FRAC_BITS = NN_FRAC_BITS,
  parameter int ACC_W     = 2*NN_DATA_W + 7
)(
  input  logic signed [ACC_W-1:0]  acc,
  input  logic signed [DATA_W-1:0] bias,
  input  logic        [1:0]        act_mode,
  output logic signed [DATA_W-1:0] result,
  output logic                     sat
);

  // One guard bit so that adding the aligned bias can never wrap.
  localparam int SUM_W = ACC_W + 1;

  localparam logic signed [SUM_W-1:0]  SUM_MAX  = {{(SUM_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0]  SUM_MIN  = {{(SUM_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic signed [DATA_W-1:0] RES_MAX  = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] RES_MIN  = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [DATA_W-1:0] RES_ZERO = {DATA_W{1'b0}};
  // 1.0 in the result format, clipped when the format cannot represent it.
  localparam logic signed [DATA_W-1:0] RES_ONE  = (FRAC_BITS >= DATA_W-1) ? RES_MAX :
                                                  ({{(DATA_W-1){1'b0}}, 1'b1} << FRAC_BITS);

  logic signed [SUM_W-1:0]  bias_ext_s;
  logic signed [SUM_W-1:0]  sum_s;
  logic signed [SUM_W-1:0]  shr_s;
  logic signed [DATA_W-1:0] clip_s;

  // Bias alignment, rescale by arithmetic shift and saturation to DATA_W.
  always_comb begin
    bias_ext_s = {{(SUM_W-DATA_W){bias[DATA_W-1]}}, bias} <<< FRAC_BITS;
    sum_s      = {acc[ACC_W-1], acc} + bias_ext_s;
    shr_s      = sum_s >>> FRAC_BITS;
    if (shr_s > SUM_MAX) begin
      clip_s = RES_MAX;
      sat    = 1'b1;
    end else if (shr_s < SUM_MIN) begin
      clip_s = RES_MIN;
      sat    = 1'b1;
    end else begin
      clip_s = shr_s[DATA_W-1:0];
      sat    = 1'b0;
    end
  end

  // Activation on the clipped value; sat keeps describing the pre-activation value.
  always_comb begin
    case (act_mode)
      ACT_RELU: result = clip_s[DATA_W-1] ? RES_ZERO : clip_s;
      ACT_STEP: result = (clip_s > RES_ZERO) ? RES_ONE : RES_ZERO;
      default:  result = clip_s;
    endcase
  end

endmodule

// File: rtl/nn_node_mac.sv
// Single neuron: streams N_INPUTS samples through a multiply-accumulate
// against a locally stored coefficient array, then rescales, saturates and
// activates the sum and holds the result until the consumer takes it.
module nn_node_mac
  import nn_pkg::*;
#(
  parameter int DATA_W    = NN_DATA_W,
  parameter int FRAC_BITS = NN_FRAC_BITS,
  parameter int N_INPUTS  = 64,
  parameter int IDX_W     = idx_width(N_INPUTS),
  parameter int ACC_W     = 2*DATA_W + IDX_W + 1
)(
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        act_mode,
  input  logic              coef_wr_en,
  input  logic [IDX_W-1:0]  coef_addr,
  input  logic [DATA_W-1:0] coef_data,
  input  logic              bias_wr_en,
  input  logic [DATA_W-1:0] bias_data,
  output logic              coef_wr_err,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sat,
  output logic              busy
);

  node_state_t               state_r;
  node_state_t               state_nxt_s;
  logic signed [ACC_W-1:0]   acc_r;
  logic        [IDX_W-1:0]   idx_r;
  logic signed [DATA_W-1:0]  coef_r [N_INPUTS];
  logic signed [DATA_W-1:0]  bias_r;
  logic                      in_ready_r;
  logic                      out_valid_r;
  logic        [DATA_W-1:0]  out_data_r;
  logic                      out_sat_r;
  logic                      busy_r;
  logic                      coef_wr_err_r;

  logic                      accept_s;
  logic                      last_s;
  logic                      wr_window_s;
  logic                      coef_wr_ok_s;
  logic signed [2*DATA_W-1:0] prod_s;
  logic signed [ACC_W-1:0]   prod_ext_s;
  logic signed [DATA_W-1:0]  result_s;
  logic                      sat_s;

  // Handshake, write-window and full-precision product for the current beat.
  always_comb begin
    accept_s     = in_valid & in_ready_r;
    last_s       = (32'(idx_r) == (N_INPUTS - 1));
    // A beat accepted in IDLE starts a vector, which closes the write window.
    wr_window_s  = (state_r == ST_IDLE) && !accept_s;
    coef_wr_ok_s = wr_window_s && (32'(coef_addr) < N_INPUTS);
    prod_s       = (2*DATA_W)'($signed(in_data)) * (2*DATA_W)'(coef_r[idx_r]);
    prod_ext_s   = {{(ACC_W-2*DATA_W){prod_s[2*DATA_W-1]}}, prod_s};
  end

  // Next-state decode for the node sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (N_INPUTS == 1) state_nxt_s = ST_ACT;
          else               state_nxt_s = ST_ACCUM;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (accept_s && last_s) state_nxt_s = ST_ACT;
        else                    state_nxt_s = ST_ACCUM;
      end
      ST_ACT:  state_nxt_s = ST_OUT;
      ST_OUT: begin
        if (out_ready) state_nxt_s = ST_IDLE;
        else           state_nxt_s = ST_OUT;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Sequencer state, accumulator and coefficient index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      acc_r   <= '0;
      idx_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      if (accept_s) begin
        acc_r <= (state_r == ST_IDLE) ? prod_ext_s : (acc_r + prod_ext_s);
        idx_r <= (state_nxt_s == ST_ACT) ? '0 : (idx_r + IDX_W'(1));
      end else if ((state_r == ST_OUT) && out_ready) begin
        acc_r <= '0;
      end
    end
  end

  // Coefficient and bias store; writes outside the idle window are dropped and flagged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_INPUTS; i++) coef_r[i] <= '0;
      bias_r        <= '0;
      coef_wr_err_r <= 1'b0;
    end else begin
      if (coef_wr_en && coef_wr_ok_s) coef_r[coef_addr] <= $signed(coef_data);
      if (bias_wr_en && wr_window_s)  bias_r <= $signed(bias_data);
      coef_wr_err_r <= (coef_wr_en && !coef_wr_ok_s) || (bias_wr_en && !wr_window_s);
    end
  end

  nn_activation #(
    .DATA_W    (DATA_W),
    .FRAC_BITS (FRAC_BITS),
    .ACC_W     (ACC_W)
  ) u_act (
    .acc      (acc_r),
    .bias     (bias_r),
    .act_mode (act_mode),
    .result   (result_s),
    .sat      (sat_s)
  );

  // Registered status and result outputs; the result is captured in ACT and held through OUT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready_r  <= 1'b0;
      busy_r      <= 1'b0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_sat_r   <= 1'b0;
    end else begin
      in_ready_r <= (state_nxt_s == ST_IDLE) || (state_nxt_s == ST_ACCUM);
      busy_r     <= (state_nxt_s != ST_IDLE);
      if (state_r == ST_ACT) begin
        out_valid_r <= 1'b1;
        out_data_r  <= result_s;
        out_sat_r   <= sat_s;
      end else if ((state_r == ST_OUT) && out_ready) begin
        out_valid_r <= 1'b0;
      end
    end
  end

  assign in_ready    = in_ready_r;
  assign busy        = busy_r;
  assign out_valid   = out_valid_r;
  assign out_data    = out_data_r;
  assign out_sat     = out_sat_r;
  assign coef_wr_err = coef_wr_err_r;

endmodule

// File: tb/tb_nn_node_mac.sv
// Self-checking bench for nn_node_mac (DATA_W=16, FRAC_BITS=8, N_INPUTS=4).
module tb_nn_node_mac;

  localparam int DW = 16;
  localparam int FB = 8;
  localparam int NI = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [1:0]    act_mode = 2'd0;
  logic          coef_wr_en = 1'b0;
  logic [IW-1:0] coef_addr = '0;
  logic [DW-1:0] coef_data = '0;
  logic          bias_wr_en = 1'b0;
  logic [DW-1:0] bias_data = '0;
  logic          coef_wr_err;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_sat;
  logic          busy;

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] coef_m [NI];
  logic [DW-1:0] bias_m;
  logic [DW-1:0] smp [NI];

  always #5 clk = ~clk;

  nn_node_mac #(.DATA_W(DW), .FRAC_BITS(FB), .N_INPUTS(NI)) dut (
    .clk(clk), .rst(rst), .act_mode(act_mode),
    .coef_wr_en(coef_wr_en), .coef_addr(coef_addr), .coef_data(coef_data),
    .bias_wr_en(bias_wr_en), .bias_data(bias_data), .coef_wr_err(coef_wr_err),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sat(out_sat), .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: dot product in Q8 with plain integer arithmetic, floor rescale, clip, activate.
  function automatic void model(input int mode, output logic [DW-1:0] r, output logic s);
    longint acc;
    acc = 0;
    for (int i = 0; i < NI; i++)
      acc += longint'($signed(smp[i])) * longint'($signed(coef_m[i]));
    acc += longint'($signed(bias_m)) * (longint'(1) << FB);
    acc = acc >>> FB;
    s = (acc > 32767) || (acc < -32768);
    if (acc > 32767) acc = 32767;
    else if (acc < -32768) acc = -32768;
    case (mode)
      1: if (acc < 0) acc = 0;
      2: acc = (acc > 0) ? 256 : 0;
      default: ;
    endcase
    r = acc[DW-1:0];
  endfunction

  task automatic load_params();
    for (int i = 0; i < NI; i++) begin
      coef_wr_en = 1'b1; coef_addr = IW'(i); coef_data = coef_m[i];
      tick();
      coef_wr_en = 1'b0;
      n_vec++;
      if (coef_wr_err !== 1'b0) begin
        n_err++; $display("FAIL load_coef_err: got %b expected 0", coef_wr_err);
      end
    end
    bias_wr_en = 1'b1; bias_data = bias_m;
    tick();
    bias_wr_en = 1'b0;
  endtask

  task automatic drive_beat(input logic [DW-1:0] d);
    bit took;
    took = 1'b0;
    in_valid = 1'b1; in_data = d;
    for (int t = 0; t < 100 && !took; t++) begin
      took = in_ready;
      tick();
    end
    in_valid = 1'b0;
    if (!took) begin
      n_vec++; n_err++; $display("FAIL beat_timeout: in_ready never seen");
    end
  endtask

  task automatic send_vector(input int max_gap);
    for (int i = 0; i < NI; i++) begin
      drive_beat(smp[i]);
      if (i < NI-1) repeat ($urandom_range(max_gap)) tick();
    end
  endtask

  task automatic wait_valid();
    int t;
    t = 0;
    while (!out_valid && t < 50) begin tick(); t++; end
    if (!out_valid) begin
      n_vec++; n_err++; $display("FAIL out_valid_timeout: no result within 50 cycles");
    end
  endtask

  task automatic get_result(input int delay, output logic [DW-1:0] d, output logic s);
    wait_valid();
    repeat (delay) tick();
    d = out_data; s = out_sat;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic set_basic();
    for (int i = 0; i < NI; i++) begin
      coef_m[i] = 16'h0100;
      smp[i]    = 16'(i + 1) << FB;
    end
    bias_m = 16'h0000;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    n_vec++;
    if ({in_ready, out_valid, out_data, out_sat, busy, coef_wr_err} !== 21'd0) begin
      n_err++; $display("FAIL reset_outputs: got %h expected 0",
                        {in_ready, out_valid, out_data, out_sat, busy, coef_wr_err});
    end
    tick(); tick();
    rst = 1'b0;
    tick();
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
  endtask

  task automatic test_basic();
    logic [DW-1:0] d; logic s;
    set_basic(); load_params(); act_mode = 2'd0;
    drive_beat(smp[0]);
    n_vec++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy: got %b expected 1", busy); end
    for (int i = 1; i < NI; i++) drive_beat(smp[i]);
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_latency_early: got %b expected 0", out_valid); end
    tick();
    n_vec++;
    if (out_valid !== 1'b1) begin n_err++; $display("FAIL basic_latency: got %b expected 1", out_valid); end
    get_result(0, d, s);
    n_vec++;
    if (d !== 16'h0A00) begin n_err++; $display("FAIL basic_data: got %h expected 0a00", d); end
    n_vec++;
    if (s !== 1'b0) begin n_err++; $display("FAIL basic_sat: got %b expected 0", s); end
  endtask

  task automatic test_act_modes();
    logic [DW-1:0] d; logic s;
    set_basic(); bias_m = 16'hF000; load_params();
    act_mode = 2'd1; send_vector(0); get_result(0, d, s);
    n_vec++;
    if (d !== 16'h0000) begin n_err++; $display("FAIL relu_data: got %h expected 0000", d); end
    act_mode = 2'd0; send_vector(0); get_result(0, d, s);
    n_vec++;
    if (d !== 16'hFA00) begin n_err++; $display("FAIL ident_neg_data: got %h expected fa00", d); end
    n_vec++;
    if (s !== 1'b0) begin n_err++; $display("FAIL ident_neg_sat: got %b expected 0", s); end
    bias_m = 16'h0000; load_params();
    act_mode = 2'd2; send_vector(0); get_result(0, d, s);
    n_vec++;
    if (d !== 16'h0100) begin n_err++; $display("FAIL step_data: got %h expected 0100", d); end
  endtask

  task automatic test_saturation();
    logic [DW-1:0] d; logic s;
    for (int i = 0; i < NI; i++) begin coef_m[i] = 16'h7FFF; smp[i] = 16'h7FFF; end
    bias_m = 16'h0000; load_params();
    act_mode = 2'd0; send_vector(1); get_result(0, d, s);
    n_vec++;
    if ({d, s} !== {16'h7FFF, 1'b1}) begin n_err++; $display("FAIL sat_pos: got %h/%b expected 7fff/1", d, s); end
    for (int i = 0; i < NI; i++) smp[i] = 16'h8001;
    send_vector(1); get_result(0, d, s);
    n_vec++;
    if ({d, s} !== {16'h8000, 1'b1}) begin n_err++; $display("FAIL sat_neg: got %h/%b expected 8000/1", d, s); end
    act_mode = 2'd1; send_vector(0); get_result(0, d, s);
    n_vec++;
    if ({d, s} !== {16'h0000, 1'b1}) begin n_err++; $display("FAIL sat_relu: got %h/%b expected 0000/1", d, s); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] d; logic s;
    set_basic(); load_params(); act_mode = 2'd0;
    send_vector(0);
    wait_valid();
    in_valid = 1'b1; in_data = 16'h7FFF;
    for (int k = 0; k < 5; k++) begin
      n_vec++;
      if ({out_valid, out_data, in_ready} !== {1'b1, 16'h0A00, 1'b0}) begin
        n_err++; $display("FAIL hold_cycle%0d: got v=%b d=%h rdy=%b expected 1/0a00/0", k, out_valid, out_data, in_ready);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0; in_valid = 1'b0;
    n_vec++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_err++; $display("FAIL after_handshake: got rdy=%b v=%b expected 1/0", in_ready, out_valid);
    end
    send_vector(0); get_result(0, d, s);
    n_vec++;
    if (d !== 16'h0A00) begin n_err++; $display("FAIL bp_next_vector: got %h expected 0a00", d); end
  endtask

  task automatic test_wr_while_busy();
    logic [DW-1:0] d; logic s;
    set_basic(); load_params(); act_mode = 2'd0;
    drive_beat(smp[0]); drive_beat(smp[1]);
    coef_wr_en = 1'b1; coef_addr = 2'd0; coef_data = 16'h0000;
    tick();
    coef_wr_en = 1'b0;
    n_vec++;
    if (coef_wr_err !== 1'b1) begin n_err++; $display("FAIL busy_wr_err: got %b expected 1", coef_wr_err); end
    tick();
    n_vec++;
    if (coef_wr_err !== 1'b0) begin n_err++; $display("FAIL busy_wr_err_pulse: got %b expected 0", coef_wr_err); end
    drive_beat(smp[2]); drive_beat(smp[3]);
    get_result(0, d, s);
    n_vec++;
    if (d !== 16'h0A00) begin n_err++; $display("FAIL busy_wr_data: got %h expected 0a00", d); end
    coef_wr_en = 1'b1; coef_addr = 2'd1; coef_data = 16'h0000;
    drive_beat(smp[0]);
    coef_wr_en = 1'b0;
    n_vec++;
    if (coef_wr_err !== 1'b1) begin n_err++; $display("FAIL first_beat_wr_err: got %b expected 1", coef_wr_err); end
    for (int i = 1; i < NI; i++) drive_beat(smp[i]);
    get_result(0, d, s);
    n_vec++;
    if (d !== 16'h0A00) begin n_err++; $display("FAIL first_beat_wr_data: got %h expected 0a00", d); end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] d; logic s;
    int seen;
    set_basic(); load_params(); act_mode = 2'd0;
    drive_beat(smp[0]); drive_beat(smp[1]);
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if ({in_ready, out_valid, out_data, out_sat, busy, coef_wr_err} !== 21'd0) begin
      n_err++; $display("FAIL midrst_outputs: got %h expected 0",
                        {in_ready, out_valid, out_data, out_sat, busy, coef_wr_err});
    end
    tick(); tick();
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 6; k++) begin if (out_valid) seen++; tick(); end
    n_vec++;
    if (seen !== 0) begin n_err++; $display("FAIL midrst_no_valid: got %0d valid cycles expected 0", seen); end
    send_vector(0); get_result(0, d, s);
    n_vec++;
    if (d !== 16'h0000) begin n_err++; $display("FAIL midrst_coef_cleared: got %h expected 0000", d); end
    load_params(); send_vector(0); get_result(0, d, s);
    n_vec++;
    if (d !== 16'h0A00) begin n_err++; $display("FAIL midrst_replay: got %h expected 0a00", d); end
  endtask

  task automatic test_random();
    logic [DW-1:0] d, exp_d; logic s, exp_s;
    int mode;
    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < NI; i++) begin
        if (k % 2 == 0) begin
          coef_m[i] = 16'($urandom_range(2047)) - 16'd1024;
          smp[i]    = 16'($urandom_range(4095)) - 16'd2048;
        end else begin
          coef_m[i] = 16'($urandom);
          smp[i]    = 16'($urandom);
        end
      end
      bias_m = (k % 2 == 0) ? (16'($urandom_range(4095)) - 16'd2048) : 16'($urandom);
      mode = $urandom_range(3);
      load_params();
      act_mode = 2'(mode);
      send_vector(2);
      get_result($urandom_range(3), d, s);
      model(mode, exp_d, exp_s);
      n_vec++;
      if ({d, s} !== {exp_d, exp_s}) begin
        n_err++; $display("FAIL random%0d mode%0d: got %h/%b expected %h/%b", k, mode, d, s, exp_d, exp_s);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_act_modes();
    test_saturation();
    test_backpressure();
    test_wr_while_busy();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
